// File: rtl/vram_pkg.sv
`default_nettype none
// ============================================================================
// Package : vram_pkg
// Shared constants and helpers for the SPRAM-backed video RAM.
// Rev     : 1.0
// ============================================================================
package vram_pkg;

  localparam int BANK_AW = 14;

  localparam logic [3:0] LANE0_MASK = 4'b0011;
  localparam logic [3:0] LANE1_MASK = 4'b1100;
  localparam logic [3:0] FULL_MASK  = 4'b1111;

  // Byte-wide storage needs one extra address bit for the lane select.
  function automatic int calc_addr_width(input int data_width, input int num_banks);
    return BANK_AW + $clog2(num_banks) + ((data_width == 8) ? 1 : 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spram_bank.sv
`default_nettype none
// ============================================================================
// Module : spram_bank
// One 16Kx16 SPRAM bank with nibble write mask and byte replication; the
// storage is a behavioural equivalent of SB_SPRAM256KA (registered read).
// Rev    : 1.0
// ============================================================================
module spram_bank
  import vram_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  wren,
  input  logic                  lane,
  input  logic [BANK_AW-1:0]    addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [15:0]           dataout
);

  localparam logic CHIPSELECT = 1'b1;
  localparam logic SLEEP      = 1'b0;
  localparam logic STANDBY    = 1'b0;
  localparam logic POWEROFF   = 1'b1;

  logic [15:0] mem [0:(1 << BANK_AW)-1];
  logic [15:0] w_wdata;
  logic [3:0]  w_mask;
  logic        w_active;

  assign w_active = CHIPSELECT && !SLEEP && !STANDBY && POWEROFF;

  generate
    if (DATA_WIDTH == 8) begin : g_byte
      assign w_wdata = {wdata, wdata};
      assign w_mask  = lane ? LANE1_MASK : LANE0_MASK;
    end else begin : g_word
      assign w_wdata = wdata;
      assign w_mask  = FULL_MASK;
    end
  endgenerate

  // Like the hard macro, the output register only updates on read cycles.
  always_ff @(posedge clk) begin
    if (w_active) begin
      if (wren) begin
        for (int n = 0; n < 4; n++) begin
          if (w_mask[n]) mem[addr][n*4 +: 4] <= w_wdata[n*4 +: 4];
        end
      end else begin
        dataout <= mem[addr];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spram_arb_ram.sv
`default_nettype none
// ============================================================================
// Module : spram_arb_ram
// SPRAM store shared by a read-only video port and a read/write CPU port,
// with fixed video priority and a bounded CPU wait.
// Rev    : 1.0
// ============================================================================
module spram_arb_ram
  import vram_pkg::*;
#(
  parameter  int DATA_WIDTH   = 8,
  parameter  int NUM_BANKS    = 1,
  parameter  int MAX_CPU_WAIT = 3,
  localparam int ADDR_WIDTH   = calc_addr_width(DATA_WIDTH, NUM_BANKS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vid_req,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  output logic                  vid_gnt,
  output logic                  vid_rvalid,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int         BANK_W   = $clog2(NUM_BANKS);
  localparam int         BANK_IW  = (BANK_W == 0) ? 1 : BANK_W;
  localparam int         LANE_W   = (DATA_WIDTH == 8) ? 1 : 0;
  localparam int         LOW_W    = ADDR_WIDTH - BANK_W;
  localparam logic [3:0] WAIT_MAX = 4'(MAX_CPU_WAIT);

  logic [3:0]            r_wait_cnt;
  logic                  r_vid_rvalid;
  logic                  r_cpu_rvalid;
  logic [BANK_IW-1:0]    r_bank;
  logic                  r_lane;
  logic [DATA_WIDTH-1:0] r_hold;

  logic                  w_cpu_wins;
  logic                  w_wr_gnt;
  logic                  w_rd_gnt;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [BANK_IW-1:0]    w_bank;
  logic                  w_lane;
  logic [BANK_AW-1:0]    w_word;
  logic [15:0]           w_bank_out [0:(1 << BANK_IW)-1];
  logic [15:0]           w_sel_word;
  logic [DATA_WIDTH-1:0] w_mux;
  logic                  w_any_rvalid;

  // The CPU only overrides video once it has lost MAX_CPU_WAIT times in a row.
  assign w_cpu_wins = cpu_req && (!vid_req || (r_wait_cnt == WAIT_MAX));
  assign cpu_gnt    = !reset && w_cpu_wins;
  assign vid_gnt    = !reset && vid_req && !w_cpu_wins;
  assign w_wr_gnt   = cpu_gnt && cpu_we;
  assign w_rd_gnt   = vid_gnt || (cpu_gnt && !cpu_we);

  assign w_addr = cpu_gnt ? cpu_addr : vid_addr;
  assign w_bank = BANK_IW'(w_addr >> LOW_W);
  assign w_lane = (LANE_W == 1) ? w_addr[0] : 1'b0;
  assign w_word = BANK_AW'(w_addr >> LANE_W);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt   <= 4'd0;
      r_vid_rvalid <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_bank       <= '0;
      r_lane       <= 1'b0;
    end else begin
      if (!cpu_req || cpu_gnt) begin
        r_wait_cnt <= 4'd0;
      end else if (r_wait_cnt != WAIT_MAX) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end
      r_vid_rvalid <= vid_gnt;
      r_cpu_rvalid <= cpu_gnt && !cpu_we;
      if (w_rd_gnt) begin
        r_bank <= w_bank;
        r_lane <= w_lane;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < (1 << BANK_IW); gi++) begin : g_bank
      if (gi < NUM_BANKS) begin : g_inst
        spram_bank #(
          .DATA_WIDTH (DATA_WIDTH)
        ) u_bank (
          .clk     (clk),
          .wren    (w_wr_gnt && (w_bank == BANK_IW'(gi))),
          .lane    (w_lane),
          .addr    (w_word),
          .wdata   (cpu_wdata),
          .dataout (w_bank_out[gi])
        );
      end else begin : g_tie
        assign w_bank_out[gi] = 16'h0000;
      end
    end
  endgenerate

  assign w_sel_word = w_bank_out[r_bank];

  generate
    if (DATA_WIDTH == 8) begin : g_dw8
      assign w_mux = r_lane ? w_sel_word[15:8] : w_sel_word[7:0];
    end else begin : g_dw16
      assign w_mux = w_sel_word;
    end
  endgenerate

  // Reset in the data cycle discards the in-flight read.
  assign vid_rvalid   = r_vid_rvalid && !reset;
  assign cpu_rvalid   = r_cpu_rvalid && !reset;
  assign w_any_rvalid = vid_rvalid || cpu_rvalid;

  // Banks keep reading on idle cycles, so the last delivered word is latched.
  always_ff @(posedge clk) begin
    if (w_any_rvalid) r_hold <= w_mux;
  end

  assign rdata = w_any_rvalid ? w_mux : r_hold;

endmodule
`default_nettype wire

// File: tb/tb_spram_arb_ram.sv
`default_nettype none
// ============================================================================
// Module : tb_spram_arb_ram
// Scoreboard bench: byte-wide two-bank instance under random traffic plus a
// word-wide four-bank instance for decode checks.
// Rev    : 1.0
// ============================================================================
module tb_spram_arb_ram;

  localparam int MAXW = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        vid_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] vid_addr = '0, cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        vid_gnt, cpu_gnt, vid_rvalid, cpu_rvalid;
  logic [7:0]  rdata;

  logic        h_vid_req = 1'b0, h_cpu_req = 1'b0, h_cpu_we = 1'b0;
  logic [15:0] h_vid_addr = '0, h_cpu_addr = '0, h_cpu_wdata = '0;
  logic        h_vid_gnt, h_cpu_gnt, h_vid_rvalid, h_cpu_rvalid;
  logic [15:0] h_rdata;

  spram_arb_ram #(.DATA_WIDTH(8), .NUM_BANKS(2), .MAX_CPU_WAIT(MAXW)) u_d8 (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt), .vid_rvalid(vid_rvalid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .rdata(rdata));

  spram_arb_ram #(.DATA_WIDTH(16), .NUM_BANKS(4), .MAX_CPU_WAIT(MAXW)) u_d16 (
    .clk(clk), .reset(reset),
    .vid_req(h_vid_req), .vid_addr(h_vid_addr), .vid_gnt(h_vid_gnt), .vid_rvalid(h_vid_rvalid),
    .cpu_req(h_cpu_req), .cpu_we(h_cpu_we), .cpu_addr(h_cpu_addr), .cpu_wdata(h_cpu_wdata),
    .cpu_gnt(h_cpu_gnt), .cpu_rvalid(h_cpu_rvalid), .rdata(h_rdata));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    bit         known;
  } exp_t;

  exp_t       vq[$];
  exp_t       cq[$];
  logic [7:0] mem_model [0:65535];
  bit         written   [0:65535];
  logic [15:0] pool [0:23];
  int         lose_cnt = 0;
  logic [7:0] last_data;
  bit         have_last = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] pick_addr();
    return pool[$urandom_range(23)];
  endfunction

  always @(posedge clk) cyc++;

  // Issue side: arbitration rule check and expected-response push.
  always @(negedge clk) begin
    exp_t e;
    bit   exp_cpu;
    if (reset) begin
      check("gnt_in_reset", {vid_gnt, cpu_gnt}, 2'b00);
      lose_cnt = 0;
    end else begin
      exp_cpu = cpu_req && (!vid_req || lose_cnt >= MAXW);
      check("arb_cpu_gnt", cpu_gnt, exp_cpu);
      check("arb_vid_gnt", vid_gnt, vid_req && !exp_cpu);
      if (vid_gnt) begin
        e.cyc = cyc; e.data = mem_model[vid_addr]; e.known = written[vid_addr];
        vq.push_back(e);
      end
      if (cpu_gnt) begin
        if (cpu_we) begin
          mem_model[cpu_addr] = cpu_wdata;
          written[cpu_addr]   = 1'b1;
        end else begin
          e.cyc = cyc; e.data = mem_model[cpu_addr]; e.known = written[cpu_addr];
          cq.push_back(e);
        end
      end
      lose_cnt = (cpu_req && !cpu_gnt) ? lose_cnt + 1 : 0;
    end
  end

  // Response side: pops the scoreboard whenever read data is due.
  always @(negedge clk) begin
    exp_t e;
    bit   ev, ec;
    if (reset) begin
      check("rvalid_in_reset", {vid_rvalid, cpu_rvalid}, 2'b00);
      vq.delete();
      cq.delete();
    end else begin
      ev = (vq.size() > 0) && (vq[0].cyc == cyc - 1);
      ec = (cq.size() > 0) && (cq[0].cyc == cyc - 1);
      check("vid_rvalid", vid_rvalid, ev);
      check("cpu_rvalid", cpu_rvalid, ec);
      if (ev || ec) begin
        e = ev ? vq.pop_front() : cq.pop_front();
        if (e.known) check(ev ? "vid_rdata" : "cpu_rdata", rdata, e.data);
        last_data = e.data;
        have_last = e.known;
      end else if (have_last) begin
        check("rdata_hold", rdata, last_data);
      end
    end
  end

  task automatic cpu_issue(input bit we, input logic [15:0] a, input logic [7:0] d);
    int t = 0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    do begin
      @(negedge clk);
      t++;
    end while (!cpu_gnt && t < 40);
    if (!cpu_gnt) check("cpu_gnt_wait", cpu_gnt, 1'b1);
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic cpu_read_expect(input logic [15:0] a, input logic [7:0] d);
    cpu_issue(1'b0, a, d);
    @(negedge clk);
    check("cpu_read_data", rdata, d);
  endtask

  task automatic random_traffic(input int n, input int pv, input int pc);
    bit gv, gc;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      gv = vid_gnt; gc = cpu_gnt;
      @(posedge clk); #1;
      if (!vid_req || gv) begin
        vid_req  = ($urandom_range(99) < pv);
        vid_addr = pick_addr();
      end else if ($urandom_range(99) < 3) begin
        vid_req = 1'b0;
      end
      if (!cpu_req || gc) begin
        cpu_req   = ($urandom_range(99) < pc);
        cpu_we    = 1'($urandom_range(1));
        cpu_addr  = pick_addr();
        cpu_wdata = 8'($urandom);
      end else if ($urandom_range(99) < 4) begin
        cpu_req = 1'b0;
      end
    end
    @(posedge clk); #1;
    vid_req = 1'b0; cpu_req = 1'b0;
  endtask

  task automatic h_access(input bit we, input logic [15:0] a, input logic [15:0] d,
                          input logic [3:0] bank_oh);
    logic [3:0] wr;
    @(posedge clk); #1;
    h_cpu_req = 1'b1; h_cpu_we = we; h_cpu_addr = a; h_cpu_wdata = d;
    @(negedge clk);
    check("h_cpu_gnt", h_cpu_gnt, 1'b1);
    wr = {u_d16.g_bank[3].g_inst.u_bank.wren, u_d16.g_bank[2].g_inst.u_bank.wren,
          u_d16.g_bank[1].g_inst.u_bank.wren, u_d16.g_bank[0].g_inst.u_bank.wren};
    check(we ? "h_bank_wren" : "h_read_no_wren", wr, we ? bank_oh : 4'b0000);
    @(posedge clk); #1;
    h_cpu_req = 1'b0;
    @(negedge clk);
    check("h_cpu_rvalid", h_cpu_rvalid, !we);
    if (!we) check("h_rdata", h_rdata, d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pre;
    bit         gv, gc;
    for (int i = 0; i < 8; i++) pool[i] = 16'(i);
    pool[8]  = 16'h7FFF; pool[9]  = 16'h8000; pool[10] = 16'h8001;
    pool[11] = 16'hFFFE; pool[12] = 16'hFFFF; pool[13] = 16'h4000;
    for (int i = 14; i < 24; i++) pool[i] = 16'($urandom);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Lane isolation within one word.
    cpu_issue(1'b1, 16'h0001, 8'hA5);
    cpu_issue(1'b1, 16'h0000, 8'h3C);
    cpu_read_expect(16'h0001, 8'hA5);
    cpu_read_expect(16'h0000, 8'h3C);

    for (int i = 2; i < 24; i++) cpu_issue(1'b1, pool[i], 8'($urandom));
    cpu_read_expect(16'hFFFF, mem_model[16'hFFFF]);

    // Both requesting continuously: video x3 then CPU, repeating.
    @(posedge clk); #1;
    vid_req = 1'b1; vid_addr = pick_addr();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = pick_addr();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("pattern_cpu_gnt", cpu_gnt, (k % 4) == 3);
      check("pattern_vid_gnt", vid_gnt, (k % 4) != 3);
      gv = vid_gnt; gc = cpu_gnt;
      @(posedge clk); #1;
      if (gv) vid_addr = pick_addr();
      if (gc) cpu_addr = pick_addr();
    end
    vid_req = 1'b0; cpu_req = 1'b0;

    // Video streaming reads 0..7.
    @(posedge clk); #1;
    vid_req = 1'b1; vid_addr = 16'd0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("vid_stream_gnt", vid_gnt, 1'b1);
      @(posedge clk); #1;
      vid_addr = 16'(k + 1);
    end
    vid_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset right after a read grant, with a write pending through reset.
    pre = mem_model[16'h0000];
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0001;
    @(negedge clk);
    check("pre_reset_gnt", cpu_gnt, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0000; cpu_wdata = ~pre;
    @(negedge clk);
    check("reset_kills_rvalid", cpu_rvalid, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; cpu_req = 1'b0;
    cpu_read_expect(16'h0000, pre);

    // CPU write abandoned while losing to video.
    @(posedge clk); #1;
    pre = mem_model[16'h0002];
    vid_req = 1'b1; vid_addr = 16'h0003;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0002; cpu_wdata = ~pre;
    @(negedge clk);
    check("abandon_no_gnt0", cpu_gnt, 1'b0);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(negedge clk);
    check("abandon_no_gnt1", cpu_gnt, 1'b0);
    @(posedge clk); #1;
    vid_req = 1'b0;
    cpu_read_expect(16'h0002, pre);

    random_traffic(800, 60, 60);
    random_traffic(600, 95, 40);
    cpu_read_expect(16'hFFFF, mem_model[16'hFFFF]);

    // Word-wide, four-bank decode.
    h_access(1'b1, 16'h0000, 16'h1234, 4'b0001);
    h_access(1'b1, 16'hFFFF, 16'hBEEF, 4'b1000);
    h_access(1'b1, 16'h4001, 16'h5A5A, 4'b0010);
    h_access(1'b0, 16'h0000, 16'h1234, 4'b0000);
    h_access(1'b0, 16'hFFFF, 16'hBEEF, 4'b0000);
    h_access(1'b0, 16'h4001, 16'h5A5A, 4'b0000);

    repeat (3) @(negedge clk);
    check("vid_queue_drained", vq.size(), 0);
    check("cpu_queue_drained", cq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
